// File: rtl/tmds_pkg.sv
// tmds_pkg: shared types, symbol constants and helper functions for the
// pipelined TMDS encoder.
//   mode_e       - symbol mode carried down the pipe (video / control / TERC4)
//   CTRL_xx      - the four 10-bit control symbols, indexed by {c1,c0}
//   decode_mode  - folds the raw 2-bit mode input onto mode_e (11 -> control)
//   popcount8    - number of ones in a byte
//   ctrl_lut     - {c1,c0} -> 10-bit control symbol
//   terc4_lut    - 4-bit TERC4 nibble -> 10-bit data-island symbol
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_VIDEO = 2'b00,
        MODE_CTRL  = 2'b01,
        MODE_TERC4 = 2'b10
    } mode_e;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // The unused encoding 11 is deliberately treated as control so that a
    // glitching mux never produces a video symbol that disturbs disparity.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'b00:   m = MODE_VIDEO;
            2'b10:   m = MODE_TERC4;
            default: m = MODE_CTRL;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(b[i]);
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_lut(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_lut(input logic [3:0] n);
        logic [9:0] s;
        case (n)
            4'd0:    s = 10'b1010011100;
            4'd1:    s = 10'b1001100011;
            4'd2:    s = 10'b1011100100;
            4'd3:    s = 10'b1011100010;
            4'd4:    s = 10'b0101110001;
            4'd5:    s = 10'b0100011110;
            4'd6:    s = 10'b0110001110;
            4'd7:    s = 10'b0100111100;
            4'd8:    s = 10'b1011001100;
            4'd9:    s = 10'b0100111001;
            4'd10:   s = 10'b0110011100;
            4'd11:   s = 10'b1011000110;
            4'd12:   s = 10'b1010001110;
            4'd13:   s = 10'b1001110001;
            4'd14:   s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tmds_encoder_pipe_channel.sv
// tmds_channel: one TMDS lane. Stage 1 does the 8b->9b transition-minimising
// encode, stage 2 does DC balancing against a running disparity counter, or
// emits a control / TERC4 symbol (which clears the counter).
//   clk_in, rst_in  - pixel clock, async active-high reset
//   s0_valid_in     - symbol presented at data_in/ctrl_in/terc_in is valid
//   s1_valid_in     - stage-1 registers hold a valid symbol (piped by top)
//   mode_in         - raw 2-bit mode for this symbol
//   data_in         - video byte
//   ctrl_in         - {c1,c0}
//   terc_in         - TERC4 nibble
//   tmds_out        - registered 10-bit output symbol
module tmds_channel
    import tmds_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       s0_valid_in,
    input  logic       s1_valid_in,
    input  logic [1:0] mode_in,
    input  logic [7:0] data_in,
    input  logic [1:0] ctrl_in,
    input  logic [3:0] terc_in,
    output logic [9:0] tmds_out
);

    localparam logic signed [CNT_W-1:0] ZERO  = '0;
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

    logic [8:0] qm_d, qm_q;
    logic [3:0] n1_d, n1_q;
    mode_e      mode_d, mode_q;
    logic [1:0] ctrl_d, ctrl_q;
    logic [3:0] terc_d, terc_q;

    logic [9:0]              tmds_d, tmds_q;
    logic signed [CNT_W-1:0] cnt_d, cnt_q;

    // Stage 1 next-state: transition-minimise the incoming byte. The XNOR
    // chain is chosen for dense bytes so that qm has few transitions; qm[8]
    // records which chain was used so the receiver can undo it. The popcount
    // of qm is computed here so stage 2 only has to compare and add.
    always_comb begin
        logic [3:0] n1_data;
        logic       use_xnor;
        logic [8:0] qm_w;
        qm_d     = qm_q;
        n1_d     = n1_q;
        mode_d   = mode_q;
        ctrl_d   = ctrl_q;
        terc_d   = terc_q;
        n1_data  = popcount8(data_in);
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data_in[0]);
        qm_w     = '0;
        qm_w[0]  = data_in[0];
        for (int i = 1; i < 8; i++) begin
            qm_w[i] = use_xnor ? ~(data_in[i] ^ qm_w[i-1]) : (data_in[i] ^ qm_w[i-1]);
        end
        qm_w[8] = ~use_xnor;
        if (s0_valid_in) begin
            qm_d   = qm_w;
            n1_d   = popcount8(qm_w[7:0]);
            mode_d = decode_mode(mode_in);
            ctrl_d = ctrl_in;
            terc_d = terc_in;
        end
    end

    // Stage 1 registers: they only load on a valid symbol, so a bubble
    // leaves the previous contents in place (stage 2 ignores them anyway).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            qm_q   <= '0;
            n1_q   <= '0;
            mode_q <= MODE_VIDEO;
            ctrl_q <= '0;
            terc_q <= '0;
        end else begin
            qm_q   <= qm_d;
            n1_q   <= n1_d;
            mode_q <= mode_d;
            ctrl_q <= ctrl_d;
            terc_q <= terc_d;
        end
    end

    // Stage 2 next-state: for video, pick whether to invert qm[7:0] so the
    // running disparity is pulled back towards zero, and update the counter.
    // The popcount is zero-extended into the signed counter width; diff is
    // N1-N0 = 2*N1-8. Control and TERC4 symbols are DC balanced on their
    // own, so they simply restart the disparity at zero. A bubble holds
    // both the output symbol and the counter.
    always_comb begin
        logic signed [CNT_W-1:0] n1_s;
        logic signed [CNT_W-1:0] diff;
        logic                    cnt_pos;
        logic                    cnt_neg;
        tmds_d  = tmds_q;
        cnt_d   = cnt_q;
        n1_s    = $signed({{(CNT_W-4){1'b0}}, n1_q});
        diff    = n1_s + n1_s - EIGHT;
        cnt_neg = cnt_q[CNT_W-1];
        cnt_pos = !cnt_q[CNT_W-1] && (cnt_q != ZERO);
        if (s1_valid_in) begin
            case (mode_q)
                MODE_VIDEO: begin
                    if ((cnt_q == ZERO) || (n1_q == 4'd4)) begin
                        tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                        cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
                    end else if ((cnt_pos && (n1_q > 4'd4)) || (cnt_neg && (n1_q < 4'd4))) begin
                        tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                        cnt_d  = cnt_q + (qm_q[8] ? TWO : ZERO) - diff;
                    end else begin
                        tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
                        cnt_d  = cnt_q - (qm_q[8] ? ZERO : TWO) + diff;
                    end
                end
                MODE_TERC4: begin
                    tmds_d = terc4_lut(terc_q);
                    cnt_d  = ZERO;
                end
                default: begin
                    tmds_d = ctrl_lut(ctrl_q);
                    cnt_d  = ZERO;
                end
            endcase
        end
    end

    // Stage 2 registers: output symbol and running disparity.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tmds_q <= '0;
            cnt_q  <= '0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds_out = tmds_q;

endmodule

// File: rtl/tmds_encoder_pipe.sv
// tmds_encoder_pipe: NUM_CH-lane pipelined TMDS encoder with video,
// control and TERC4 modes. Two-clock latency, one symbol per clock.
//   clk_in, rst_in  - pixel clock, async active-high reset
//   valid_in        - input symbol valid (low = bubble)
//   mode_in         - 00 video, 01 control, 10 TERC4, 11 control
//   data_in         - NUM_CH video bytes, lane k at [8k+7:8k]
//   ctrl_in         - NUM_CH {c1,c0} pairs
//   terc_in         - NUM_CH TERC4 nibbles
//   tmds_out        - NUM_CH 10-bit symbols, lane k at [10k+9:10k]
//   valid_out       - tmds_out carries a new symbol this cycle
module tmds_encoder_pipe
    import tmds_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    input  logic [1:0]           mode_in,
    input  logic [NUM_CH*8-1:0]  data_in,
    input  logic [NUM_CH*2-1:0]  ctrl_in,
    input  logic [NUM_CH*4-1:0]  terc_in,
    output logic [NUM_CH*10-1:0] tmds_out,
    output logic                 valid_out
);

    logic v1_d, v1_q;
    logic v2_d, v2_q;

    // The valid flag simply follows the symbol down the two stages; the
    // stage-1 copy also tells each lane whether stage 2 should update.
    always_comb begin
        v1_d = valid_in;
        v2_d = v1_q;
    end

    // Valid pipe registers, cleared by reset so no stale symbol escapes.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    assign valid_out = v2_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tmds_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .s0_valid_in (valid_in),
            .s1_valid_in (v1_q),
            .mode_in     (mode_in),
            .data_in     (data_in[8*k +: 8]),
            .ctrl_in     (ctrl_in[2*k +: 2]),
            .terc_in     (terc_in[4*k +: 4]),
            .tmds_out    (tmds_out[10*k +: 10])
        );
    end

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// tb_tmds_encoder_pipe: directed, table-driven bench for the 3-lane TMDS
// encoder. A table of symbols is streamed back to back and each expected
// output is compared two clocks later; the async-reset corner is driven by
// a hand-written sequence at the end.
module tb_tmds_encoder_pipe;

    localparam int NUM_CH = 3;

    logic                 clk_in;
    logic                 rst_in;
    logic                 valid_in;
    logic [1:0]           mode_in;
    logic [NUM_CH*8-1:0]  data_in;
    logic [NUM_CH*2-1:0]  ctrl_in;
    logic [NUM_CH*4-1:0]  terc_in;
    logic [NUM_CH*10-1:0] tmds_out;
    logic                 valid_out;

    typedef struct {
        logic        valid;
        logic [1:0]  mode;
        logic [23:0] data;
        logic [5:0]  ctrl;
        logic [11:0] terc;
        logic [29:0] exp_tmds;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];
    int   check_count;
    int   pass_count;

    tmds_encoder_pipe #(
        .NUM_CH(NUM_CH),
        .CNT_W (5)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .valid_in (valid_in),
        .mode_in  (mode_in),
        .data_in  (data_in),
        .ctrl_in  (ctrl_in),
        .terc_in  (terc_in),
        .tmds_out (tmds_out),
        .valid_out(valid_out)
    );

    // Free-running pixel clock, rising edges at 5, 15, 25 ...
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic logic [29:0] rep3(input logic [9:0] s);
        return {s, s, s};
    endfunction

    function automatic vec_t mk(input logic v, input logic [1:0] m, input logic [23:0] d,
                                input logic [5:0] c, input logic [11:0] t,
                                input logic [29:0] e, input logic ev);
        vec_t r;
        r.valid     = v;
        r.mode      = m;
        r.data      = d;
        r.ctrl      = c;
        r.terc      = t;
        r.exp_tmds  = e;
        r.exp_valid = ev;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        valid_in = v.valid;
        mode_in  = v.mode;
        data_in  = v.data;
        ctrl_in  = v.ctrl;
        terc_in  = v.terc;
    endtask

    task automatic checkOutput(input string name, input logic [29:0] actual, input logic [29:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    // Symbol table: expected values are hand-derived, ch2 is the leftmost field.
    initial begin
        logic [29:0] s1, s2, s3, s4, s5, s6;
        vec_t idle;
        check_count = 0;
        pass_count  = 0;
        s1 = {10'b0111110000, 10'b1000000000, 10'b0100000000};
        s2 = {10'b0111110000, 10'b0011111111, 10'b1111111111};
        s3 = {10'b0111110000, 10'b0011111111, 10'b0100000000};
        s4 = {10'b0111110000, 10'b1000000000, 10'b1111111111};
        s5 = {10'b0111110000, 10'b0011111111, 10'b0100000000};
        s6 = {10'b0111110000, 10'b1000000000, 10'b1111111111};

        // control symbols, including the 11 mode alias
        vecs.push_back(mk(1, 2'b01, 24'h0, 6'b000000, 12'h0, rep3(10'b1101010100), 1));
        vecs.push_back(mk(1, 2'b01, 24'h0, 6'b111111, 12'h0, rep3(10'b1010101011), 1));
        vecs.push_back(mk(1, 2'b11, 24'h0, 6'b101010, 12'h0, rep3(10'b0101010100), 1));
        vecs.push_back(mk(1, 2'b01, 24'h0, 6'b010101, 12'h0, rep3(10'b0010101011), 1));
        // video from zero disparity: 00 -> -8, 00 -> +2, FF -> -6
        vecs.push_back(mk(1, 2'b00, 24'h000000, 6'b0, 12'h0, rep3(10'b0100000000), 1));
        vecs.push_back(mk(1, 2'b00, 24'h000000, 6'b0, 12'h0, rep3(10'b1111111111), 1));
        vecs.push_back(mk(1, 2'b00, 24'hFFFFFF, 6'b0, 12'h0, rep3(10'b1000000000), 1));
        // control clears disparity between two 0x00 bytes
        vecs.push_back(mk(1, 2'b01, 24'h0, 6'b000000, 12'h0, rep3(10'b1101010100), 1));
        vecs.push_back(mk(1, 2'b00, 24'h000000, 6'b0, 12'h0, rep3(10'b0100000000), 1));
        vecs.push_back(mk(1, 2'b01, 24'h0, 6'b000000, 12'h0, rep3(10'b1101010100), 1));
        vecs.push_back(mk(1, 2'b00, 24'h000000, 6'b0, 12'h0, rep3(10'b0100000000), 1));
        vecs.push_back(mk(1, 2'b01, 24'h0, 6'b111111, 12'h0, rep3(10'b1010101011), 1));
        vecs.push_back(mk(1, 2'b00, 24'hFFFFFF, 6'b0, 12'h0, rep3(10'b1000000000), 1));
        // TERC4, different nibble per lane
        vecs.push_back(mk(1, 2'b10, 24'h0, 6'b0, 12'hF50,
                          {10'b1011000011, 10'b0100011110, 10'b1010011100}, 1));
        vecs.push_back(mk(1, 2'b10, 24'h0, 6'b0, 12'hC83,
                          {10'b1010001110, 10'b1011001100, 10'b1011100010}, 1));
        vecs.push_back(mk(1, 2'b10, 24'h0, 6'b0, 12'hD96,
                          {10'b1001110001, 10'b0100111001, 10'b0110001110}, 1));
        // independent lanes with a three-cycle gap; disparity must survive it
        vecs.push_back(mk(1, 2'b00, 24'h10FF00, 6'b0, 12'h0, s1, 1));
        vecs.push_back(mk(1, 2'b00, 24'h10FF00, 6'b0, 12'h0, s2, 1));
        vecs.push_back(mk(1, 2'b00, 24'h10FF00, 6'b0, 12'h0, s3, 1));
        vecs.push_back(mk(0, 2'b10, 24'hAAAAAA, 6'b101010, 12'h123, s3, 0));
        vecs.push_back(mk(0, 2'b01, 24'h555555, 6'b010101, 12'h456, s3, 0));
        vecs.push_back(mk(0, 2'b00, 24'hAAAAAA, 6'b111111, 12'h789, s3, 0));
        vecs.push_back(mk(1, 2'b00, 24'h10FF00, 6'b0, 12'h0, s4, 1));
        vecs.push_back(mk(1, 2'b00, 24'h10FF00, 6'b0, 12'h0, s5, 1));
        vecs.push_back(mk(1, 2'b00, 24'h10FF00, 6'b0, 12'h0, s6, 1));

        idle = mk(0, 2'b00, 24'h0, 6'b0, 12'h0, 30'h0, 0);

        // power-on reset: outputs cleared without any clock edge
        rst_in = 1'b1;
        applyStimulus(idle);
        #1;
        checkOutput("reset_tmds", tmds_out, 30'h0);
        checkOutput("reset_valid", 30'(valid_out), 30'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // stream the table back to back, checking each symbol two clocks on
        for (int i = 0; i < vecs.size() + 2; i++) begin
            if (i >= 2) begin
                checkOutput($sformatf("vec%0d_valid", i - 2), 30'(valid_out), 30'(vecs[i-2].exp_valid));
                checkOutput($sformatf("vec%0d_tmds", i - 2), tmds_out, vecs[i-2].exp_tmds);
            end
            if (i < vecs.size()) applyStimulus(vecs[i]);
            else applyStimulus(idle);
            @(negedge clk_in);
        end
        checkOutput("tail_valid", 30'(valid_out), 30'h0);
        checkOutput("tail_tmds_hold", tmds_out, s6);

        // async reset mid-stream with a symbol sitting in stage 1
        applyStimulus(mk(1, 2'b00, 24'h000000, 6'b0, 12'h0, 30'h0, 0));
        @(negedge clk_in);
        @(negedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        checkOutput("midreset_tmds", tmds_out, 30'h0);
        checkOutput("midreset_valid", 30'(valid_out), 30'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        applyStimulus(idle);
        @(negedge clk_in);
        checkOutput("post_reset_no_ghost_valid", 30'(valid_out), 30'h0);
        checkOutput("post_reset_no_ghost_tmds", tmds_out, 30'h0);
        applyStimulus(mk(1, 2'b00, 24'h000000, 6'b0, 12'h0, 30'h0, 0));
        @(negedge clk_in);
        applyStimulus(idle);
        checkOutput("post_reset_latency1_valid", 30'(valid_out), 30'h0);
        @(negedge clk_in);
        checkOutput("post_reset_valid", 30'(valid_out), 30'h1);
        checkOutput("post_reset_cnt_zero", tmds_out, rep3(10'b0100000000));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/tmds_encoder_pipe.md
Name: tmds_encoder_pipe

Overview:
- Parametrised, pipelined TMDS encoder for NUM_CH channels, built on the 8b-to-9b transition-minimisation stage.
- Adds the 10-bit DC-balancing stage with a running-disparity counter per channel.
- Adds control-symbol mode and TERC4 data-island mode.
- Sits between the video/packet mux and the 10:1 serialisers in the HDMI transmit path.

Parameters:
- NUM_CH, 3: number of independent TMDS channels.
- CNT_W, 5: width of the signed per-channel disparity counter (two's complement).

Ports:
- clk_in  input  1  pixel clock; the only clock.
- rst_in  input  1  reset, asynchronous, active-high.
- valid_in  input  1  input symbol valid; low inserts a bubble.
- mode_in  input  2  00 video, 01 control, 10 TERC4; 11 is treated as control.
- data_in  input  NUM_CH*8  video bytes; channel k is at [8k+7:8k].
- ctrl_in  input  NUM_CH*2  control bits {c1,c0} per channel.
- terc_in  input  NUM_CH*4  TERC4 nibble per channel.
- tmds_out  output  NUM_CH*10  encoded symbols; channel k is at [10k+9:10k].
- valid_out  output  1  tmds_out holds a new symbol.

Behaviour:
- Reset (asynchronous, any time including mid-stream): tmds_out=0, valid_out=0, all stage registers=0, every disparity cnt=0. The first valid symbol after reset release starts the 2-cycle latency afresh.
- Latency is exactly 2 clocks from valid_in to valid_out. Throughput is 1 symbol/clock. There is no backpressure.
- Stage 1, registered, per channel:
  - N1(data) = popcount of the byte.
  - XNOR path when N1>4, or N1==4 and data[0]==0: qm[0]=d[0]; qm[i]=~(d[i]^qm[i-1]); qm[8]=0.
  - Otherwise XOR path: qm[i]=d[i]^qm[i-1]; qm[8]=1.
  - Register qm[8:0], N1(qm[7:0]), mode, ctrl and terc, all qualified by valid_in.
- Stage 2, registered, per channel, video mode. N1/N0 are counts over qm[7:0]:
  - Case A, cnt==0 or N1==N0:
    - out = {~qm8, qm8, qm8 ? qm[7:0] : ~qm[7:0]}.
    - cnt += qm8 ? (N1-N0) : (N0-N1).
  - Case B, (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, qm8, ~qm[7:0]}.
    - cnt = cnt + 2*qm8 + (N0-N1).
  - Case C, otherwise:
    - out = {0, qm8, qm[7:0]}.
    - cnt = cnt - 2*(~qm8) + (N1-N0).
  - Arithmetic is signed CNT_W bits. The operands are sign-extended and the popcounts are zero-extended.
- Control mode, out[9:0] by {c1,c0}, with cnt forced to 0:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- TERC4 mode, nibble 0..15 mapped to out[9:0], with cnt forced to 0:
  - 0-3: 1010011100, 1001100011, 1011100100, 1011100010
  - 4-7: 0101110001, 0100011110, 0110001110, 0100111100
  - 8-11: 1011001100, 0100111001, 0110011100, 1011000110
  - 12-15: 1010001110, 1001110001, 0101100011, 1011000011
- Bubble (stage-2 input not valid): tmds_out holds its previous value, valid_out=0, cnt holds.
- Channels are fully independent. mode_in is shared across channels.
- A mode change takes effect on the symbol it accompanies; there is no extra delay.

Decomposition:
- tmds_pkg holds:
  - mode enum: MODE_VIDEO, MODE_CTRL, MODE_TERC4.
  - the 4 control-code constants.
  - the 16-entry TERC4 lookup function.
  - a popcount8 function.
- Sub-module tmds_channel: both stages and the cnt register for one channel, instantiated NUM_CH times in a generate loop. The top level only slices the buses and pipes valid.

Test Plan:
1. Reset: assert rst_in between clock edges during streaming -> tmds_out=0 and valid_out=0 immediately, with no clock. After release, cnt=0 is verified by the next 0x00 encoding to 0100000000.
2. Control: mode=01, ctrl=00 on all channels -> two cycles later tmds_out per channel = 1101010100, valid_out=1. Repeat with ctrl=11 -> 1010101011.
3. Video from cnt=0: 0x00, 0x00 -> 0100000000 (cnt=-8), then 1111111111 (cnt=2). 0xFF from cnt=0 -> 1000000000 (cnt=-8).
4. Control resets disparity: 0x00 (cnt=-8), then control, then 0x00 -> 0100000000, not 1111111111.
5. TERC4: mode=10, nibbles 0, 5, 15 -> 1010011100, 0100011110, 1011000011.
6. Bubble and channel independence: ch0=0x00, ch1=0xFF, ch2=0x10, with valid_in low for 3 cycles mid-stream.
   - valid_out=0 and tmds_out holds during the gap.
   - Post-gap symbols match a reference model per channel (cnt held across the gap).
